// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result path: widths, error-flag indices and
// a helper that sizes occupancy counters.
package alu_pkg;

  localparam int unsigned ALU_DATA_WIDTH = 64;
  localparam int unsigned ALU_OPP_WIDTH  = 4;

  // Bit positions inside the sticky error vector.
  localparam int unsigned ERR_OVERFLOW   = 0;
  localparam int unsigned ERR_UNEXPECTED = 1;

  // A counter that must represent 0..depth inclusive.
  function automatic int unsigned level_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/alu_sink_fifo.sv
// Result FIFO with a registered first-word-fall-through output stage.
// Storage uses wrap-bit pointers; o_level_o counts storage plus output register.
module alu_sink_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             push_i,
  input  logic [DATA_WIDTH-1:0]            push_data_i,
  output logic                             push_accept_o,
  output logic                             out_valid_o,
  output logic [DATA_WIDTH-1:0]            out_data_o,
  input  logic                             out_ready_i,
  output logic [level_width(FIFO_DEPTH)-1:0] level_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned LW = level_width(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [AW:0]           wr_ptr_q, wr_ptr_d;
  logic [AW:0]           rd_ptr_q, rd_ptr_d;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic [LW-1:0]         level_q, level_d;

  logic store_empty, store_full, full;
  logic pop, push_ok, load, from_mem, bypass, mem_we;

  assign store_empty = (wr_ptr_q == rd_ptr_q);
  assign store_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  // Total capacity is bounded by the level, output register included.
  assign full        = store_full || (level_q == LW'(FIFO_DEPTH));

  assign pop      = out_valid_q & out_ready_i;
  assign push_ok  = push_i & (~full | pop);
  assign load     = ~out_valid_q | pop;
  assign from_mem = load & ~store_empty;
  // Empty storage: an incoming result goes straight to the output register.
  assign bypass   = load & store_empty & push_ok;
  assign mem_we   = push_ok & ~bypass;

  // Next-state for pointers, output stage and level.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    level_d     = level_q;

    if (mem_we) wr_ptr_d = wr_ptr_q + 1'b1;

    if (load) begin
      if (from_mem) begin
        out_valid_d = 1'b1;
        out_data_d  = mem_q[rd_ptr_q[AW-1:0]];
        rd_ptr_d    = rd_ptr_q + 1'b1;
      end else if (bypass) begin
        out_valid_d = 1'b1;
        out_data_d  = push_data_i;
      end else begin
        out_valid_d = 1'b0;
      end
    end

    unique case ({push_ok, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  // Control and output registers, cleared asynchronously.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      level_q     <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      level_q     <= level_d;
    end
  end

  // Storage array; contents are don't-care while pointers say empty.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign push_accept_o = push_ok;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign level_o       = level_q;

endmodule

// File: rtl/alu_result_sink.sv
// Receiving end of the non-stallable ALU result stream. Buffers results in
// alu_sink_fifo, re-presents them as AXI-Stream with tready, grants issue
// credit so a result always has a reserved slot, and keeps sticky error flags.
// Optional packet framing (m_axis_tlast) is enabled by ALU_SINK_TLAST_EN.
module alu_result_sink
  import alu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = ALU_DATA_WIDTH,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PKT_LEN    = 8
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  input  logic                               i_issue,
  output logic                               o_issue_allow,
  input  logic [DATA_WIDTH-1:0]              s_axis_result_tdata,
  input  logic                               s_axis_result_tvalid,
  output logic [DATA_WIDTH-1:0]              m_axis_tdata,
  output logic                               m_axis_tvalid,
  input  logic                               m_axis_tready,
`ifdef ALU_SINK_TLAST_EN
  output logic                               m_axis_tlast,
`endif
  output logic [level_width(FIFO_DEPTH)-1:0] o_level,
  output logic [1:0]                         o_error,
  input  logic                               i_clear
);

  localparam int unsigned LW = level_width(FIFO_DEPTH);
  localparam int unsigned CW = LW + 1;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least 2");
  end
  if (PKT_LEN == 0) begin : g_bad_pkt_len
    $error("PKT_LEN must be at least 1");
  end

  logic          push_accept;
  logic [LW-1:0] level;
  logic [CW-1:0] inflight_q, inflight_d;
  logic [1:0]    err_q, err_d, err_set;
  logic [CW:0]   committed;

  alu_sink_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i         (aclk),
    .rst_ni        (aresetn),
    .push_i        (s_axis_result_tvalid),
    .push_data_i   (s_axis_result_tdata),
    .push_accept_o (push_accept),
    .out_valid_o   (m_axis_tvalid),
    .out_data_o    (m_axis_tdata),
    .out_ready_i   (m_axis_tready),
    .level_o       (level)
  );

  // Outstanding-operation count and sticky error next-state.
  always_comb begin
    inflight_d = inflight_q;
    unique case ({i_issue, s_axis_result_tvalid})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   if (inflight_q != '0) inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase

    err_set                 = '0;
    err_set[ERR_OVERFLOW]   = s_axis_result_tvalid & ~push_accept;
    err_set[ERR_UNEXPECTED] = s_axis_result_tvalid & (inflight_q == '0);
    // A new error in the clearing cycle survives the clear.
    err_d = (i_clear ? 2'b00 : err_q) | err_set;
  end

  // Credit and error state.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      inflight_q <= '0;
      err_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

  assign committed     = (CW + 1)'(level) + (CW + 1)'(inflight_q);
  assign o_issue_allow = committed < (CW + 1)'(FIFO_DEPTH);
  assign o_level       = level;
  assign o_error       = err_q;

`ifdef ALU_SINK_TLAST_EN
  localparam int unsigned PW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;

  logic [PW-1:0] pkt_cnt_q, pkt_cnt_d;
  logic          last_beat, pop;

  assign pop       = m_axis_tvalid & m_axis_tready;
  assign last_beat = (pkt_cnt_q == PW'(PKT_LEN - 1));

  // Beat position within the current packet.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    if (pop) pkt_cnt_d = last_beat ? '0 : pkt_cnt_q + 1'b1;
  end

  // Packet counter register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) pkt_cnt_q <= '0;
    else          pkt_cnt_q <= pkt_cnt_d;
  end

  assign m_axis_tlast = m_axis_tvalid & last_beat;
`endif

endmodule

// File: tb/tb_alu_result_sink.sv
// Directed bench for alu_result_sink: single result, credit exhaustion,
// overflow, full push/pop, backpressure ordering and (with
// ALU_SINK_TLAST_EN) packet framing across a reset.
module tb_alu_result_sink;

  localparam int unsigned DW    = 64;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned LW    = $clog2(DEPTH) + 1;

  logic          aclk;
  logic          aresetn;
  logic          i_issue;
  logic          o_issue_allow;
  logic [DW-1:0] s_axis_result_tdata;
  logic          s_axis_result_tvalid;
  logic [DW-1:0] m_axis_tdata;
  logic          m_axis_tvalid;
  logic          m_axis_tready;
  logic [LW-1:0] o_level;
  logic [1:0]    o_error;
  logic          i_clear;
`ifdef ALU_SINK_TLAST_EN
  logic          m_axis_tlast;
`endif

  int unsigned n_vec;
  int unsigned n_miss;

  alu_result_sink #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (DEPTH),
    .PKT_LEN    (8)
  ) u_dut (
    .aclk                 (aclk),
    .aresetn              (aresetn),
    .i_issue              (i_issue),
    .o_issue_allow        (o_issue_allow),
    .s_axis_result_tdata  (s_axis_result_tdata),
    .s_axis_result_tvalid (s_axis_result_tvalid),
    .m_axis_tdata         (m_axis_tdata),
    .m_axis_tvalid        (m_axis_tvalid),
    .m_axis_tready        (m_axis_tready),
`ifdef ALU_SINK_TLAST_EN
    .m_axis_tlast         (m_axis_tlast),
`endif
    .o_level              (o_level),
    .o_error              (o_error),
    .i_clear              (i_clear)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; return 1 time unit after the edge.
  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic do_reset();
    aresetn = 1'b0;
    #3;
    tick();
    aresetn = 1'b1;
    tick();
  endtask

  initial begin
    logic [63:0] exp_v;
    logic [63:0] held;
    logic        prev_stall;
    int          beat;
    n_vec = 0;
    n_miss = 0;
    i_issue = 0;
    s_axis_result_tdata = '0;
    s_axis_result_tvalid = 0;
    m_axis_tready = 0;
    i_clear = 0;
    aresetn = 1'b1;
    #2;
    do_reset();

    // Reset state
    check("rst_tvalid", 64'(m_axis_tvalid), 64'd0);
    check("rst_tdata", m_axis_tdata, 64'd0);
    check("rst_level", 64'(o_level), 64'd0);
    check("rst_error", 64'(o_error), 64'd0);
    check("rst_allow", 64'(o_issue_allow), 64'd1);

    // Single result with one-cycle latency
    m_axis_tready = 1;
    i_issue = 1; tick(); i_issue = 0;
    repeat (4) tick();
    s_axis_result_tvalid = 1; s_axis_result_tdata = 64'h2A;
    tick();
    s_axis_result_tvalid = 0;
    check("single_tvalid", 64'(m_axis_tvalid), 64'd1);
    check("single_tdata", m_axis_tdata, 64'h2A);
    check("single_allow", 64'(o_issue_allow), 64'd1);
    tick();
    check("single_drained", 64'(m_axis_tvalid), 64'd0);
    check("single_level0", 64'(o_level), 64'd0);
    check("single_allow2", 64'(o_issue_allow), 64'd1);
    check("single_err", 64'(o_error), 64'd0);

    // Credit exhaustion
    m_axis_tready = 0;
    i_issue = 1;
    repeat (15) tick();
    check("credit_15", 64'(o_issue_allow), 64'd1);
    tick();
    i_issue = 0;
    check("credit_16", 64'(o_issue_allow), 64'd0);
    s_axis_result_tvalid = 1;
    for (int i = 0; i < 16; i++) begin
      s_axis_result_tdata = 64'(i + 1);
      tick();
    end
    s_axis_result_tvalid = 0;
    check("fill_level", 64'(o_level), 64'd16);
    check("fill_allow", 64'(o_issue_allow), 64'd0);
    check("fill_err", 64'(o_error), 64'd0);
    check("fill_head", m_axis_tdata, 64'd1);

    // Forced overflow: dropped and unexpected
    s_axis_result_tvalid = 1; s_axis_result_tdata = 64'hDEAD;
    tick();
    s_axis_result_tvalid = 0;
    check("ovf_error", 64'(o_error), 64'd3);
    check("ovf_level", 64'(o_level), 64'd16);
    i_clear = 1; tick(); i_clear = 0;
    check("clear_error", 64'(o_error), 64'd0);

    // Full with simultaneous push and pop
    i_issue = 1; tick(); i_issue = 0;
    check("full_pop_head", m_axis_tdata, 64'd1);
    s_axis_result_tvalid = 1; s_axis_result_tdata = 64'hBEEF; m_axis_tready = 1;
    tick();
    s_axis_result_tvalid = 0; m_axis_tready = 0;
    check("pushpop_level", 64'(o_level), 64'd16);
    check("pushpop_err", 64'(o_error), 64'd0);
    check("pushpop_head", m_axis_tdata, 64'd2);
    check("pushpop_allow", 64'(o_issue_allow), 64'd0);
    m_axis_tready = 1; tick(); m_axis_tready = 0;
    check("pop1_level", 64'(o_level), 64'd15);
    check("pop1_allow", 64'(o_issue_allow), 64'd1);
    m_axis_tready = 1;
    for (int v = 3; v <= 17; v++) begin
      exp_v = (v == 17) ? 64'hBEEF : 64'(v);
      check("drain_valid", 64'(m_axis_tvalid), 64'd1);
      check("drain_data", m_axis_tdata, exp_v);
      tick();
    end
    check("drain_empty", 64'(m_axis_tvalid), 64'd0);
    check("drain_level", 64'(o_level), 64'd0);

    // Backpressure ordering with tready toggling
    m_axis_tready = 0;
    i_issue = 1; repeat (10) tick(); i_issue = 0;
    exp_v = 1;
    prev_stall = 0;
    held = '0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      s_axis_result_tvalid = (cyc < 10);
      s_axis_result_tdata  = 64'(cyc + 1);
      m_axis_tready = (cyc % 2 == 0);
      if (m_axis_tvalid) begin
        if (prev_stall) check("bp_hold", m_axis_tdata, held);
        if (m_axis_tready) begin
          check("bp_order", m_axis_tdata, exp_v);
          exp_v++;
        end
      end
      prev_stall = m_axis_tvalid && !m_axis_tready;
      held = m_axis_tdata;
      tick();
    end
    s_axis_result_tvalid = 0;
    m_axis_tready = 0;
    check("bp_count", exp_v, 64'd11);
    check("bp_level", 64'(o_level), 64'd0);
    check("bp_err", 64'(o_error), 64'd0);

`ifdef ALU_SINK_TLAST_EN
    // Framing: 20 results, reset after beat 18, then 8 more
    m_axis_tready = 1;
    beat = 0;
    for (int cyc = 0; cyc < 60 && beat < 18; cyc++) begin
      i_issue = (cyc < 20);
      s_axis_result_tvalid = (cyc >= 1 && cyc <= 20);
      s_axis_result_tdata = 64'(cyc);
      if (m_axis_tvalid) begin
        beat++;
        check("tlast_a", 64'(m_axis_tlast), 64'(beat % 8 == 0));
      end
      tick();
    end
    check("tlast_beats", 64'(beat), 64'd18);
    i_issue = 0; s_axis_result_tvalid = 0;
    do_reset();
    check("tlast_rst_valid", 64'(m_axis_tvalid), 64'd0);
    check("tlast_rst_last", 64'(m_axis_tlast), 64'd0);
    beat = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      i_issue = (cyc < 8);
      s_axis_result_tvalid = (cyc >= 1 && cyc <= 8);
      s_axis_result_tdata = 64'(cyc + 100);
      if (m_axis_tvalid) begin
        beat++;
        check("tlast_b", 64'(m_axis_tlast), 64'(beat == 8));
      end
      tick();
    end
    check("tlast_b_beats", 64'(beat), 64'd8);
    i_issue = 0; s_axis_result_tvalid = 0;
`else
    beat = 0;
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
